// File: rtl/wb_initiator_bfm_core.sv
// Wishbone B4 classic single-access initiator. It takes one host request at a time,
// runs it on the bus, and returns the read data and error status through a one-cycle response pulse.
module wb_initiator_bfm_core #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_adr_i,
    input  logic [DATA_WIDTH-1:0]   req_dat_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_sel_i,

    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_dat_o,
    output logic                    rsp_err_o,

    output logic [ADDR_WIDTH-1:0]   adr,
    output logic [DATA_WIDTH-1:0]   dat_w,
    input  logic [DATA_WIDTH-1:0]   dat_r,
    output logic                    cyc,
    output logic                    stb,
    output logic                    we,
    output logic [DATA_WIDTH/8-1:0] sel,
    input  logic                    ack,
    input  logic                    err
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
    logic [DATA_WIDTH-1:0]     dat_w_q, dat_w_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH/8-1:0]   sel_q, sel_d;
    logic                      cyc_q, cyc_d;
    logic                      stb_q, stb_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_dat_q, rsp_dat_d;
    logic                      rsp_err_q, rsp_err_d;

    // A request posted during reset stays with the host until the block is out of reset.
    assign req_ready_o = (state_q == IDLE) && !reset;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        state_d     = state_q;
        adr_d       = adr_q;
        dat_w_d     = dat_w_q;
        we_d        = we_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    adr_d   = req_adr_i;
                    dat_w_d = req_dat_i;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // err wins over ack when both arrive at the same edge
                if (cyc_q && stb_q && (ack || err)) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err;
                    rsp_dat_d   = we_q ? '0 : dat_r;
                    state_d     = GAP;
                end
            end
            GAP: begin
                // This cycle absorbs the lingering ack of a registered-ack target.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_w_q     <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            // An access cut short by reset is still reported once, as an error with zero data.
            rsp_valid_q <= (state_q == ACTIVE);
            rsp_err_q   <= (state_q == ACTIVE);
            rsp_dat_q   <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign adr         = adr_q;
    assign dat_w       = dat_w_q;
    assign we          = we_q;
    assign sel         = sel_q;
    assign cyc         = cyc_q;
    assign stb         = stb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator_bfm_core.sv
// Directed bench for wb_initiator_bfm_core. It drives the initiator against a registered-ack
// memory target that can also answer with err or never answer at all.
module tb_wb_initiator_bfm_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;

    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic        ack, err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    wb_initiator_bfm_core #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .req_we_i    (req_we),
        .req_sel_i   (req_sel),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .adr         (adr),
        .dat_w       (dat_w),
        .dat_r       (dat_r),
        .cyc         (cyc),
        .stb         (stb),
        .we          (we),
        .sel         (sel),
        .ack         (ack),
        .err         (err)
    );

    // Target: 0 = registered ack, 1 = registered err, 2 = never responds.
    int          mode = 0;
    logic [31:0] mem [0:255];
    logic        ack_r, err_r;

    assign ack   = ack_r;
    assign err   = err_r;
    assign dat_r = mem[adr[9:2]];

    always @(posedge clock) begin
        if (reset) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            ack_r <= (mode == 0) && cyc && stb;
            err_r <= (mode == 1) && cyc && stb;
            if ((mode == 0) && cyc && stb && we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mem[adr[9:2]][8*b +: 8] <= dat_w[8*b +: 8];
            end
        end
    end

    // Bus monitor, sampled on the falling edge.
    int   stb_hi = 0, we_hi = 0, rsp_cnt = 0, rise_cnt = 0, idle_run = 0, last_gap = 0;
    logic prev_stb = 1'b0;

    always @(negedge clock) begin
        if (cyc && stb) stb_hi <= stb_hi + 1;
        if (cyc && stb && we) we_hi <= we_hi + 1;
        if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
        if (cyc && stb && !prev_stb) begin
            rise_cnt <= rise_cnt + 1;
            last_gap <= idle_run;
        end
        idle_run <= cyc ? 0 : idle_run + 1;
        prev_stb <= stb;
    end

    task automatic post_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input logic [3:0] s, output bit accepted);
        req_adr   = a;
        req_dat   = d;
        req_we    = w;
        req_sel   = s;
        req_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (req_ready_o) begin
                @(posedge clock);
                accepted = 1'b1;
                break;
            end
            @(negedge clock);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output bit got);
        got = 1'b0;
        d   = 'x;
        e   = 1'bx;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (rsp_valid_o) begin
                d   = rsp_dat_o;
                e   = rsp_err_o;
                got = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                             input logic [3:0] s, output logic [31:0] rd, output logic re,
                             output bit ok);
        bit acc, got;
        post_req(a, d, w, s, acc);
        if (acc) wait_rsp(rd, re, got);
        else got = 1'b0;
        ok = acc && got;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            n_checks++;
            if ({cyc, stb, we} !== 3'b000 || adr !== '0 || dat_w !== '0 || sel !== '0 || rsp_valid_o !== 1'b0)
                $display("FAIL reset_outputs cycle %0d: cyc=%b stb=%b we=%b adr=%h dat_w=%h sel=%h rsp=%b want all 0",
                         i, cyc, stb, we, adr, dat_w, sel, rsp_valid_o);
            else n_pass++;
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if ({cyc, stb, we} !== 3'b000 || adr !== '0 || dat_w !== '0 || sel !== '0)
                $display("FAIL idle_outputs cycle %0d: cyc=%b stb=%b we=%b adr=%h want 0", i, cyc, stb, we, adr);
            else n_pass++;
        end
        #1;
    endtask

    task automatic test_write();
        logic [31:0] rd;
        logic        re;
        bit          ok;
        int          s0, w0;
        mode = 0;
        s0 = stb_hi;
        w0 = we_hi;
        do_access(32'h100, 32'hDEADBEEF, 1'b1, 4'hF, rd, re, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL write_complete: got %0b want 1", ok); else n_pass++;
        n_checks++;
        if (re !== 1'b0) $display("FAIL write_err: got %b want 0", re); else n_pass++;
        n_checks++;
        if (stb_hi - s0 !== 2) $display("FAIL write_stb_edges: got %0d want 2", stb_hi - s0); else n_pass++;
        n_checks++;
        if (we_hi - w0 !== 2) $display("FAIL write_we_edges: got %0d want 2", we_hi - w0); else n_pass++;
        n_checks++;
        if (mem[64] !== 32'hDEADBEEF) $display("FAIL write_mem: got %h want deadbeef", mem[64]); else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] rd;
        logic        re;
        bit          ok;
        int          s0, w0;
        mode = 0;
        s0 = stb_hi;
        w0 = we_hi;
        do_access(32'h100, 32'h0, 1'b0, 4'hF, rd, re, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL read_complete: got %0b want 1", ok); else n_pass++;
        n_checks++;
        if (rd !== 32'hDEADBEEF) $display("FAIL read_data: got %h want deadbeef", rd); else n_pass++;
        n_checks++;
        if (re !== 1'b0) $display("FAIL read_err: got %b want 0", re); else n_pass++;
        n_checks++;
        if (we_hi - w0 !== 0) $display("FAIL read_we_edges: got %0d want 0", we_hi - w0); else n_pass++;
        n_checks++;
        if (stb_hi - s0 !== 2) $display("FAIL read_stb_edges: got %0d want 2", stb_hi - s0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        re1, re2;
        bit          ok1, ok2;
        int          r0, q0;
        mode = 0;
        r0 = rsp_cnt;
        q0 = rise_cnt;
        do_access(32'h108, 32'h1, 1'b1, 4'hF, rd, re1, ok1);
        do_access(32'h108, 32'h2, 1'b1, 4'hF, rd, re2, ok2);
        n_checks++;
        if (!(ok1 && ok2) || re1 !== 1'b0 || re2 !== 1'b0)
            $display("FAIL b2b_status: ok=%0b%0b err=%b%b want 11/00", ok1, ok2, re1, re2);
        else n_pass++;
        n_checks++;
        if (rsp_cnt - r0 !== 2) $display("FAIL b2b_completions: got %0d want 2", rsp_cnt - r0); else n_pass++;
        n_checks++;
        if (rise_cnt - q0 !== 2) $display("FAIL b2b_stb_rises: got %0d want 2", rise_cnt - q0); else n_pass++;
        // The host reacts to the response pulse, which arrives during the gap cycle, so two idle clocks are expected.
        n_checks++;
        if (last_gap !== 2) $display("FAIL b2b_idle_gap: got %0d want 2", last_gap); else n_pass++;
        n_checks++;
        if (mem[66] !== 32'h2) $display("FAIL b2b_mem: got %h want 00000002", mem[66]); else n_pass++;
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic        re;
        bit          ok;
        int          s0;
        mode = 1;
        s0 = stb_hi;
        do_access(32'h200, 32'h0, 1'b0, 4'hF, rd, re, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL err_complete: got %0b want 1", ok); else n_pass++;
        n_checks++;
        if (re !== 1'b1) $display("FAIL err_flag: got %b want 1", re); else n_pass++;
        n_checks++;
        if (stb_hi - s0 !== 2) $display("FAIL err_stb_edges: got %0d want 2", stb_hi - s0); else n_pass++;
        n_checks++;
        if (cyc !== 1'b0) $display("FAIL err_cyc_drop: got %b want 0", cyc); else n_pass++;
        mode = 0;
    endtask

    task automatic test_reset_active();
        logic [31:0] rd;
        logic        re;
        bit          acc, ok;
        mode = 2;
        post_req(32'h300, 32'h0, 1'b0, 4'hF, acc);
        repeat (3) @(negedge clock);
        n_checks++;
        if (!acc || cyc !== 1'b1 || stb !== 1'b1)
            $display("FAIL abort_waiting: acc=%0b cyc=%b stb=%b want 1/1/1", acc, cyc, stb);
        else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (cyc !== 1'b0 || stb !== 1'b0 || adr !== '0)
            $display("FAIL abort_outputs: cyc=%b stb=%b adr=%h want 0/0/0", cyc, stb, adr);
        else n_pass++;
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_dat_o !== 32'h0)
            $display("FAIL abort_completion: valid=%b err=%b dat=%h want 1/1/0", rsp_valid_o, rsp_err_o, rsp_dat_o);
        else n_pass++;
        mode      = 0;
        req_adr   = 32'h104;
        req_dat   = 32'h55;
        req_we    = 1'b1;
        req_sel   = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (cyc !== 1'b0 || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0)
                $display("FAIL reset_holds_req cycle %0d: cyc=%b ready=%b rsp=%b want 0", i, cyc, req_ready_o, rsp_valid_o);
            else n_pass++;
        end
        reset = 1'b0;
        do_access(32'h104, 32'h55, 1'b1, 4'hF, rd, re, ok);
        n_checks++;
        if (ok !== 1'b1 || re !== 1'b0) $display("FAIL post_reset_write: ok=%0b err=%b want 1/0", ok, re); else n_pass++;
        n_checks++;
        if (mem[65] !== 32'h55) $display("FAIL post_reset_mem: got %h want 00000055", mem[65]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_error();
        test_reset_active();
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
